// File: rtl/riffa_chnl_pkg.sv
// Shared types and helpers for the RIFFA host-side channel endpoint.
// Holds both FSM state encodings and the word-to-beat conversion.
package riffa_chnl_pkg;

  localparam int WORD_W = 32;

  typedef enum logic [1:0] {
    R_IDLE,
    R_REQ,
    R_DATA,
    R_DONE
  } rx_state_e;

  typedef enum logic [2:0] {
    T_IDLE,
    T_ACK,
    T_DATA,
    T_DONE,
    T_WAIT
  } tx_state_e;

  // Round up to whole beats; 33-bit sum so an all-ones length cannot wrap.
  function automatic logic [31:0] len_to_beats(
    input logic [31:0] len,
    input int unsigned lg
  );
    logic [32:0] s;
    s = {1'b0, len} + 33'((1 << lg) - 1);
    return 32'(s >> lg);
  endfunction

endpackage

// File: rtl/riffa_chnl_if.sv
// RIFFA channel bundle between host endpoint and channel controller.
// The host endpoint drives RX requests/beats and acknowledges TX.
interface riffa_chnl_if #(
  parameter int W = 128
);
  logic          CHNL_RX;
  logic          CHNL_RX_LAST;
  logic [31:0]   CHNL_RX_LEN;
  logic [30:0]   CHNL_RX_OFF;
  logic          CHNL_RX_ACK;
  logic [W-1:0]  CHNL_RX_DATA;
  logic          CHNL_RX_DATA_VALID;
  logic          CHNL_RX_DATA_REN;
  logic          CHNL_TX;
  logic          CHNL_TX_LAST;
  logic [31:0]   CHNL_TX_LEN;
  logic [30:0]   CHNL_TX_OFF;
  logic          CHNL_TX_ACK;
  logic [W-1:0]  CHNL_TX_DATA;
  logic          CHNL_TX_DATA_VALID;
  logic          CHNL_TX_DATA_REN;

  modport master (
    output CHNL_RX, CHNL_RX_LAST, CHNL_RX_LEN, CHNL_RX_OFF,
    output CHNL_RX_DATA, CHNL_RX_DATA_VALID,
    input  CHNL_RX_ACK, CHNL_RX_DATA_REN,
    input  CHNL_TX, CHNL_TX_LAST, CHNL_TX_LEN, CHNL_TX_OFF,
    input  CHNL_TX_DATA, CHNL_TX_DATA_VALID,
    output CHNL_TX_ACK, CHNL_TX_DATA_REN
  );

  modport slave (
    input  CHNL_RX, CHNL_RX_LAST, CHNL_RX_LEN, CHNL_RX_OFF,
    input  CHNL_RX_DATA, CHNL_RX_DATA_VALID,
    output CHNL_RX_ACK, CHNL_RX_DATA_REN,
    output CHNL_TX, CHNL_TX_LAST, CHNL_TX_LEN, CHNL_TX_OFF,
    output CHNL_TX_DATA, CHNL_TX_DATA_VALID,
    input  CHNL_TX_ACK, CHNL_TX_DATA_REN
  );
endinterface

// File: rtl/riffa_beat_counter.sv
// 32-bit beat down-counter with last/zero flags.
// Load has priority over decrement.
module riffa_beat_counter (
  input  logic        CLK,
  input  logic        RST,
  input  logic        load_i,
  input  logic [31:0] load_val_i,
  input  logic        dec_i,
  output logic        last_o,
  output logic        zero_o
);
  logic [31:0] cnt_q, cnt_d;

  // Next count: load a fresh length or step down per beat.
  always_comb begin
    cnt_d = cnt_q;
    if (load_i)
      cnt_d = load_val_i;
    else if (dec_i && cnt_q != '0)
      cnt_d = cnt_q - 32'd1;
  end

  // Count register.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign last_o = (cnt_q == 32'd1);
  assign zero_o = (cnt_q == '0);
endmodule

// File: rtl/riffa_chnl_host_end.sv
// Host-side RIFFA channel endpoint: feeds RX from a source stream
// and drains TX into a sink stream; both halves run independently.
module riffa_chnl_host_end
  import riffa_chnl_pkg::*;
#(
  parameter int C_PCI_DATA_WIDTH = 128
) (
  input  logic                        CLK,
  input  logic                        RST,
  input  logic                        cmd_start,
  input  logic [31:0]                 cmd_len,
  input  logic [30:0]                 cmd_off,
  output logic                        cmd_busy,
  output logic                        cmd_done,
  output logic                        cmd_err,
  input  logic [C_PCI_DATA_WIDTH-1:0] src_data,
  input  logic                        src_valid,
  output logic                        src_ready,
  riffa_chnl_if.master                chnl,
  output logic [C_PCI_DATA_WIDTH-1:0] snk_data,
  output logic                        snk_valid,
  output logic                        snk_last,
  input  logic                        snk_ready,
  output logic [31:0]                 tx_len,
  output logic                        tx_last,
  output logic                        tx_done
);
  localparam int WPB = C_PCI_DATA_WIDTH / WORD_W;
  localparam int unsigned LG = $clog2(WPB);

  rx_state_e   rx_st_q, rx_st_d;
  tx_state_e   tx_st_q, tx_st_d;
  logic [31:0] len_q, tx_len_q;
  logic [30:0] off_q;
  logic        err_q, err_d, tx_last_q;
  logic        rx_load, rx_dec, rx_last, rx_zero, rx_on, rx_vld;
  logic        tx_load, tx_dec, tx_lst, tx_zero, tx_ren, tx_vld;

  riffa_beat_counter u_rx_cnt (
    .CLK        (CLK),
    .RST        (RST),
    .load_i     (rx_load),
    .load_val_i (len_to_beats(cmd_len, LG)),
    .dec_i      (rx_dec),
    .last_o     (rx_last),
    .zero_o     (rx_zero)
  );

  riffa_beat_counter u_tx_cnt (
    .CLK        (CLK),
    .RST        (RST),
    .load_i     (tx_load),
    .load_val_i (len_to_beats(chnl.CHNL_TX_LEN, LG)),
    .dec_i      (tx_dec),
    .last_o     (tx_lst),
    .zero_o     (tx_zero)
  );

  // RX next state: request, stream beats, pulse done; reject empty starts.
  always_comb begin
    rx_st_d = rx_st_q;
    rx_load = 1'b0;
    rx_dec  = 1'b0;
    rx_on   = 1'b0;
    rx_vld  = 1'b0;
    err_d   = 1'b0;
    case (rx_st_q)
      R_IDLE: begin
        if (cmd_start) begin
          if (cmd_len != '0) begin
            rx_load = 1'b1;
            rx_st_d = R_REQ;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      R_REQ: begin
        rx_on = 1'b1;
        if (chnl.CHNL_RX_ACK)
          rx_st_d = rx_zero ? R_DONE : R_DATA;
      end
      R_DATA: begin
        rx_on  = 1'b1;
        rx_vld = src_valid;
        rx_dec = src_valid & chnl.CHNL_RX_DATA_REN;
        if (rx_dec && rx_last) rx_st_d = R_DONE;
      end
      R_DONE:  rx_st_d = R_IDLE;
      default: rx_st_d = R_IDLE;
    endcase
  end

  // TX next state: ack once, forward beats, pulse done, wait for release.
  always_comb begin
    tx_st_d = tx_st_q;
    tx_load = 1'b0;
    tx_dec  = 1'b0;
    tx_ren  = 1'b0;
    tx_vld  = 1'b0;
    case (tx_st_q)
      T_IDLE: begin
        if (chnl.CHNL_TX) begin
          tx_load = 1'b1;
          tx_st_d = T_ACK;
        end
      end
      T_ACK:   tx_st_d = tx_zero ? T_DONE : T_DATA;
      T_DATA: begin
        tx_vld = chnl.CHNL_TX_DATA_VALID;
        tx_ren = snk_ready;
        tx_dec = tx_vld & tx_ren;
        if (tx_dec && tx_lst) tx_st_d = T_DONE;
      end
      T_DONE:  tx_st_d = T_WAIT;
      T_WAIT:  if (!chnl.CHNL_TX) tx_st_d = T_IDLE;
      default: tx_st_d = T_IDLE;
    endcase
  end

  // State and latched request registers; reset abandons any transfer.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      rx_st_q   <= R_IDLE;
      tx_st_q   <= T_IDLE;
      len_q     <= '0;
      off_q     <= '0;
      err_q     <= 1'b0;
      tx_len_q  <= '0;
      tx_last_q <= 1'b0;
    end else begin
      rx_st_q <= rx_st_d;
      tx_st_q <= tx_st_d;
      err_q   <= err_d;
      if (rx_load) begin
        len_q <= cmd_len;
        off_q <= cmd_off;
      end
      if (tx_load) begin
        tx_len_q  <= chnl.CHNL_TX_LEN;
        tx_last_q <= chnl.CHNL_TX_LAST;
      end
    end
  end

  assign cmd_busy = (rx_st_q != R_IDLE);
  assign cmd_done = (rx_st_q == R_DONE);
  assign cmd_err  = err_q;
  assign src_ready = rx_vld & chnl.CHNL_RX_DATA_REN;

  assign chnl.CHNL_RX            = rx_on;
  assign chnl.CHNL_RX_LAST       = rx_on;
  assign chnl.CHNL_RX_LEN        = len_q;
  assign chnl.CHNL_RX_OFF        = off_q;
  assign chnl.CHNL_RX_DATA_VALID = rx_vld;
  assign chnl.CHNL_RX_DATA       = (rx_st_q == R_DATA) ? src_data : '0;

  assign chnl.CHNL_TX_ACK      = (tx_st_q == T_ACK);
  assign chnl.CHNL_TX_DATA_REN = tx_ren;

  assign snk_valid = tx_vld;
  assign snk_last  = (tx_st_q == T_DATA) & tx_lst;
  assign snk_data  = (tx_st_q == T_DATA) ? chnl.CHNL_TX_DATA : '0;
  assign tx_len    = tx_len_q;
  assign tx_last   = tx_last_q;
  assign tx_done   = (tx_st_q == T_DONE);
endmodule
